// File: rtl/mem_port_arb_defs.sv
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// grant identifiers and bus width.
package mem_port_arb_defs;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_CPU = 2'd1,
    ACC_DMA = 2'd2
  } arb_state_e;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin selector: on a tie the requester that was not granted
// last time wins; next_last_o is the last-grant value to store if the grant is taken.
module rr_pick2
  import mem_port_arb_defs::*;
(
  input  logic req_cpu_i,
  input  logic req_dma_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic valid_o,
  output logic next_last_o
);

  always_comb begin
    grant_o = GRANT_CPU;
    valid_o = req_cpu_i | req_dma_i;
    if (req_cpu_i && req_dma_i) begin
      grant_o = (last_grant_i == GRANT_CPU) ? GRANT_DMA : GRANT_CPU;
    end else if (req_dma_i) begin
      grant_o = GRANT_DMA;
    end
    next_last_o = valid_o ? grant_o : last_grant_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between the MEM stage and a DMA loader with wait
// states and round-robin arbitration. Define MEM_PORT_ARB_PERF_EN for perf counters.
module mem_port_arbiter
  import mem_port_arb_defs::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_dma_grants
`endif
);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  logic cpu_req;
  logic pick_grant, pick_valid, pick_next_last;

  assign cpu_req = cpu_memread | cpu_memwrite;

  rr_pick2 u_pick (
    .req_cpu_i    (cpu_req),
    .req_dma_i    (dma_req),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant),
    .valid_o      (pick_valid),
    .next_last_o  (pick_next_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= GRANT_DMA;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_grant_d   = last_grant_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    we_d           = we_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    cpu_rdata      = '0;
    dma_rdata      = '0;
    dma_ack        = 1'b0;
    cpu_stall      = cpu_req;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = (pick_grant == GRANT_CPU) ? ACC_CPU : ACC_DMA;
          cnt_d        = CNT_W'(WAIT_STATES);
          last_grant_d = pick_next_last;
          // A CPU with both strobes high is treated as a store.
          addr_d  = (pick_grant == GRANT_CPU) ? cpu_addr     : dma_addr;
          wdata_d = (pick_grant == GRANT_CPU) ? cpu_wdata    : dma_wdata;
          we_d    = (pick_grant == GRANT_CPU) ? cpu_memwrite : dma_we;
        end
      end
      ACC_CPU, ACC_DMA: begin
        mem_address    = addr_q;
        mem_write_data = wdata_q;
        mem_read       = ~we_q;
        if (cnt_q == '0) begin
          state_d   = IDLE;
          mem_write = we_q;
          if (state_q == ACC_CPU) begin
            cpu_stall = 1'b0;
            if (!we_q) cpu_rdata = mem_read_data;
          end else begin
            dma_ack = 1'b1;
            if (!we_q) dma_rdata = mem_read_data;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_dma_q;
  logic        dma_grant;

  assign dma_grant = (state_q == IDLE) && pick_valid && (pick_grant == GRANT_DMA);

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_dma_q   <= '0;
    end else begin
      if (cpu_stall && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_q <= perf_stall_q + 32'd1;
      if (dma_grant && (perf_dma_q != 32'hFFFF_FFFF))   perf_dma_q   <= perf_dma_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_dma_grants   = perf_dma_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic, all compared against a cycle-numbered transaction model.
module tb_mem_port_arbiter;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_memread, cpu_memwrite;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_stall_cycles, perf_dma_grants;
`endif

  mem_port_arbiter #(.WAIT_STATES(WS), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_memread    (cpu_memread),
    .cpu_memwrite   (cpu_memwrite),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_stall      (cpu_stall),
    .dma_req        (dma_req),
    .dma_we         (dma_we),
    .dma_addr       (dma_addr),
    .dma_wdata      (dma_wdata),
    .dma_rdata      (dma_rdata),
    .dma_ack        (dma_ack),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_dma_grants   (perf_dma_grants)
`endif
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge, plus a preload path.
  logic [31:0] tbmem [16];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_data;
  assign mem_read_data = tbmem[mem_address[5:2]];
  always @(posedge clk) begin
    if (pl_en) tbmem[pl_idx] <= pl_data;
    else if (mem_write) tbmem[mem_address[5:2]] <= mem_write_data;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding access described by owner and done cycle.
  logic [31:0] mmem [16];
  bit          m_busy, m_owner, m_last, m_we;
  int          m_cyc = 0, m_done_cyc;
  logic [31:0] m_addr, m_wdata;
  int          m_perf_stall, m_perf_dma;
  bit          p_cpu_done, p_dma_ack;

  logic        obs_stall, obs_mread, obs_mwrite, obs_ack;
  logic [31:0] obs_crdata, obs_drdata;
`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] obs_perf_stall, obs_perf_dma;
`endif

  task automatic model_reset();
    m_busy = 0;
    m_last = 1;
    m_perf_stall = 0;
    m_perf_dma = 0;
    p_cpu_done = 0;
    p_dma_ack = 0;
  endtask

  // Checks one cycle at the falling edge, then advances the model past the rising edge.
  task automatic step();
    bit          done, creq, e_stall, g;
    logic [31:0] rd;
    @(negedge clk);
    done    = m_busy && (m_cyc == m_done_cyc);
    rd      = mmem[m_addr[5:2]];
    creq    = cpu_memread | cpu_memwrite;
    e_stall = creq && !(done && m_owner == 0);
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("mem_read", 32'(mem_read), 32'(m_busy && !m_we));
    chk("mem_write", 32'(mem_write), 32'(done && m_we));
    chk("mem_address", mem_address, m_busy ? m_addr : 32'h0);
    chk("mem_write_data", mem_write_data, m_busy ? m_wdata : 32'h0);
    chk("dma_ack", 32'(dma_ack), 32'(done && m_owner == 1));
    chk("cpu_rdata", cpu_rdata, (done && m_owner == 0 && !m_we) ? rd : 32'h0);
    chk("dma_rdata", dma_rdata, (done && m_owner == 1 && !m_we) ? rd : 32'h0);
`ifdef MEM_PORT_ARB_PERF_EN
    chk("perf_stall", perf_stall_cycles, 32'(m_perf_stall));
    chk("perf_dma", perf_dma_grants, 32'(m_perf_dma));
    obs_perf_stall = perf_stall_cycles;
    obs_perf_dma   = perf_dma_grants;
`endif
    obs_stall = cpu_stall; obs_mread = mem_read; obs_mwrite = mem_write;
    obs_ack = dma_ack; obs_crdata = cpu_rdata; obs_drdata = dma_rdata;

    p_cpu_done = done && m_owner == 0;
    p_dma_ack  = done && m_owner == 1;
    if (e_stall) m_perf_stall++;
    if (done) begin
      if (m_we) mmem[m_addr[5:2]] = m_wdata;
      m_busy = 0;
    end else if (!m_busy && (creq || dma_req)) begin
      g = (creq && dma_req) ? !m_last : dma_req;
      m_busy = 1; m_owner = g; m_last = g;
      m_done_cyc = m_cyc + WS + 1;
      m_addr  = g ? dma_addr  : cpu_addr;
      m_wdata = g ? dma_wdata : cpu_wdata;
      m_we    = g ? dma_we    : cpu_memwrite;
      if (g) m_perf_dma++;
    end
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    cpu_memread = rd; cpu_memwrite = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  int  acks;
  bit  dma_wait;

  initial begin
    pl_en = 0; pl_idx = '0; pl_data = '0;
    set_cpu(1, 0, 32'h0, 32'h0);
    set_dma(0, 0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_stall_req", 32'(cpu_stall), 32'd1);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    chk("rst_dma_ack", 32'(dma_ack), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dma_rdata", dma_rdata, 32'h0);
    cpu_memread = 0;
    #1;
    chk("rst_stall_idle", 32'(cpu_stall), 32'd0);

    for (int i = 0; i < 16; i++) begin
      pl_en = 1; pl_idx = 4'(i);
      pl_data = (i == 4) ? 32'hDEAD_BEEF : $urandom;
      mmem[i] = pl_data;
      @(posedge clk);
      #1;
    end
    pl_en = 0;
    reset = 1'b1;
    model_reset();

    // CPU load of 0x10: stalled cycles 0-2, data in cycle 3.
    $display("txn cpu_load addr=00000010");
    set_cpu(1, 0, 32'h10, 32'h0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("ld_stall", 32'(obs_stall), 32'(c < 3));
      chk("ld_mem_read", 32'(obs_mread), 32'(c >= 1));
      if (c == 3) chk("ld_rdata", obs_crdata, 32'hDEAD_BEEF);
    end
    set_cpu(0, 0, 32'h0, 32'h0);

    // CPU store, then DMA reads it back.
    $display("txn cpu_store addr=00000020 data=12345678");
    set_cpu(0, 1, 32'h20, 32'h1234_5678);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("st_mem_write", 32'(obs_mwrite), 32'(c == 3));
    end
    set_cpu(0, 0, 32'h0, 32'h0);
    $display("txn dma_read addr=00000020");
    set_dma(1, 0, 32'h20, 32'h0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("dr_ack", 32'(obs_ack), 32'(c == 3));
      if (c == 3) chk("dr_rdata", obs_drdata, 32'h1234_5678);
    end
    set_dma(0, 0, 32'h0, 32'h0);

    // Tie after reset: CPU first; CPU re-requests at the turnaround and DMA wins that tie.
    do_reset();
    $display("txn tie cpu_load/dma_read then cpu_store/dma_read");
    set_cpu(1, 0, 32'h04, 32'h0);
    set_dma(1, 0, 32'h08, 32'h0);
    for (int c = 0; c < 12; c++) begin
      if (c == 4) set_cpu(0, 1, 32'h0C, 32'hA5A5_5A5A);
      if (c == 8) set_dma(0, 0, 32'h0, 32'h0);
      step();
      chk("tie_stall", 32'(obs_stall), 32'(!(c == 3 || c == 11)));
      chk("tie_ack", 32'(obs_ack), 32'(c == 7));
    end
    set_cpu(0, 0, 32'h0, 32'h0);

    // DMA write whose request drops in access cycle 1 still commits.
    $display("txn dma_write addr=00000030 data=cafef00d (req dropped)");
    set_dma(1, 1, 32'h30, 32'hCAFE_F00D);
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) set_dma(0, 0, 32'h0, 32'h0);
      step();
      if (obs_ack) acks++;
      chk("dw_mem_write", 32'(obs_mwrite), 32'(c == 3));
    end
    chk("dw_ack_count", 32'(acks), 32'd1);
    set_dma(1, 0, 32'h30, 32'h0);
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 3) chk("dw_readback", obs_drdata, 32'hCAFE_F00D);
    end
    set_dma(0, 0, 32'h0, 32'h0);

    // Reset during a CPU store at cnt = 1 must suppress the write.
    $display("txn cpu_store addr=00000024 aborted by reset");
    set_cpu(0, 1, 32'h24, 32'h0BAD_CAFE);
    step();
    step();
    #2;
    chk("ab_pre_write", 32'(mem_write), 32'd0);
    reset = 1'b0;
    #1;
    chk("ab_mem_read", 32'(mem_read), 32'd0);
    chk("ab_mem_write", 32'(mem_write), 32'd0);
    chk("ab_mem_address", mem_address, 32'h0);
    chk("ab_mem_wdata", mem_write_data, 32'h0);
    set_cpu(0, 0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    step();
    set_cpu(1, 0, 32'h24, 32'h0);
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 3) chk("ab_no_commit", obs_crdata, mmem[9]);
    end
    set_cpu(0, 0, 32'h0, 32'h0);

`ifdef MEM_PORT_ARB_PERF_EN
    do_reset();
    $display("txn perf three back-to-back cpu loads");
    for (int k = 0; k < 3; k++) begin
      set_cpu(1, 0, 32'(k * 4), 32'h0);
      repeat (4) step();
    end
    set_cpu(0, 0, 32'h0, 32'h0);
    step();
    chk("perf_stall_9", obs_perf_stall, 32'd9);
    chk("perf_dma_0", obs_perf_dma, 32'd0);
`endif

    // Randomized traffic; the CPU holds its op until its done cycle, DMA until ack.
    $display("txn random traffic 800 cycles");
    dma_wait = 0;
    for (int n = 0; n < 800; n++) begin
      if (!(cpu_memread | cpu_memwrite) || p_cpu_done) begin
        case ($urandom_range(0, 7))
          3, 4:    set_cpu(1, 0, 32'($urandom_range(0, 15)) << 2, $urandom);
          5, 6:    set_cpu(0, 1, 32'($urandom_range(0, 15)) << 2, $urandom);
          7:       set_cpu(1, 1, 32'($urandom_range(0, 15)) << 2, $urandom);
          default: set_cpu(0, 0, 32'h0, 32'h0);
        endcase
      end else if (m_busy && m_owner == 0 && $urandom_range(0, 2) == 0) begin
        cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      if (p_dma_ack) begin
        dma_wait = 0;
        dma_req = 0;
      end
      if (!dma_wait) begin
        if ($urandom_range(0, 2) == 0) begin
          set_dma(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
          dma_wait = 1;
        end
      end else if (m_busy && m_owner == 1) begin
        if (dma_req && $urandom_range(0, 3) == 0) dma_req = 0;
        if ($urandom_range(0, 2) == 0) begin
          dma_addr = $urandom; dma_wdata = $urandom;
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
